// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG sampling controller.
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int unsigned DEF_SETTLE_CYC = 4;
  localparam int unsigned DEF_REP_LIMIT  = 32;
  localparam int unsigned BYTE_W         = 8;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann pair filter: of each sample pair (a,b), a!=b yields bit a, a==b yields nothing.
module trng_vn_debias (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic samp_stb,
  input  logic samp_bit,
  output logic acc_stb,
  output logic acc_bit
);

  logic have_a;
  logic a_bit;

  // The first sample of a pair is parked; clr drops an unpaired half-sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_a <= 1'b0;
      a_bit  <= 1'b0;
    end else if (clr) begin
      have_a <= 1'b0;
    end else if (samp_stb) begin
      if (have_a) begin
        have_a <= 1'b0;
      end else begin
        have_a <= 1'b1;
        a_bit  <= samp_bit;
      end
    end
  end

  assign acc_stb = samp_stb & have_a & (a_bit ^ samp_bit) & ~clr;
  assign acc_bit = a_bit;

endmodule

// File: rtl/trng_sample_ctrl.sv
// Entropy-cell sampling FSM with byte assembly and repetition-count health check.
// Define TRNG_VN_DEBIAS_EN to insert the von Neumann pair filter between sampler and byte.
module trng_sample_ctrl
  import trng_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              run,
  input  logic              ent_y,
  output logic [1:0]        en_samp_in,
  output logic              en_samp_out,
  output logic [BYTE_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              hlth_fail
);

  localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);
  localparam int unsigned CNT_W = $clog2(BYTE_W);
  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [REP_W-1:0] REP_MAX     = REP_W'(REP_LIMIT);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(BYTE_W - 1);

  state_t              state_q, state_d;
  logic [1:0]          sync_q;
  logic [7:0]          settle_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [BYTE_W-1:0]   shift_q;
  logic [BYTE_W-1:0]   rnd_data_q;
  logic [REP_W-1:0]    rep_cnt_q;
  logic                rep_last_q;
  logic                hlth_fail_q;

  logic samp_raw, rep_hit, fail, go, samp_stb;
  logic acc_stb, acc_bit, byte_done;

  assign samp_raw  = sync_q[1];
  assign rep_hit   = (rep_cnt_q == REP_MAX);
  // The raw count is watched directly so the FSM stops the cycle the limit is hit,
  // one cycle before the sticky flag becomes visible.
  assign fail      = hlth_fail_q | rep_hit;
  assign go        = ena & run & ~fail;
  assign samp_stb  = (state_q == SAMPLE) & go;
  assign byte_done = acc_stb & (bit_cnt_q == LAST_BIT);

`ifdef TRNG_VN_DEBIAS_EN
  logic debias_clr;
  assign debias_clr = (state_q == IDLE);

  trng_vn_debias u_debias (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (debias_clr),
    .samp_stb (samp_stb),
    .samp_bit (samp_raw),
    .acc_stb  (acc_stb),
    .acc_bit  (acc_bit)
  );
`else
  assign acc_stb = samp_stb;
  assign acc_bit = samp_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    en_samp_in  = 2'b00;
    en_samp_out = 1'b0;
    rnd_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) state_d = ARM;
      end
      ARM: begin
        en_samp_in = 2'b11;
        if (!go)                 state_d = IDLE;
        else if (settle_q == '0) state_d = SAMPLE;
      end
      SAMPLE: begin
        en_samp_out = 1'b1;
        if (!go)            state_d = IDLE;
        else if (byte_done) state_d = HOLD;
        else                state_d = ARM;
      end
      HOLD: begin
        rnd_valid = 1'b1;
        if (rnd_ready) state_d = go ? ARM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: synchronizer, settle timer, repetition counter and MSB-first byte assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b00;
      settle_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rnd_data_q  <= '0;
      rep_cnt_q   <= '0;
      rep_last_q  <= 1'b0;
      hlth_fail_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], ent_y};
      hlth_fail_q <= hlth_fail_q | rep_hit;

      if (state_d == ARM && state_q != ARM)
        settle_q <= SETTLE_LOAD;
      else if (state_q == ARM && settle_q != '0)
        settle_q <= settle_q - 8'd1;

      if (samp_stb) begin
        rep_last_q <= samp_raw;
        if (rep_cnt_q == '0 || samp_raw != rep_last_q)
          rep_cnt_q <= REP_W'(1);
        else if (!rep_hit)
          rep_cnt_q <= rep_cnt_q + REP_W'(1);
      end

      if (state_d == IDLE) begin
        bit_cnt_q <= '0;
      end else if (acc_stb) begin
        shift_q <= {shift_q[BYTE_W-2:0], acc_bit};
        if (byte_done) begin
          bit_cnt_q  <= '0;
          rnd_data_q <= {shift_q[BYTE_W-2:0], acc_bit};
        end else begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign rnd_data  = rnd_data_q;
  assign hlth_fail = hlth_fail_q;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Scoreboard bench for trng_sample_ctrl; follows TRNG_VN_DEBIAS_EN when it is defined.
module tb_trng_sample_ctrl;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       run = 1'b0;
  logic       ent_y = 1'b0;
  logic       rnd_ready = 1'b0;
  logic [1:0] en_samp_in;
  logic       en_samp_out;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       hlth_fail;

  always #5 clk = ~clk;

  trng_sample_ctrl #(.SETTLE_CYC(SETTLE), .REP_LIMIT(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .run         (run),
    .ent_y       (ent_y),
    .en_samp_in  (en_samp_in),
    .en_samp_out (en_samp_out),
    .rnd_data    (rnd_data),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .hlth_fail   (hlth_fail)
  );

  int total = 0;
  int bad = 0;
  bit ent_q[$];
  logic [7:0] exp_q[$];
  int samp_pulses = 0;
  int arm_cycles = 0;
  int valid_cycles = 0;
  int xfers = 0;
  int arm_run = 0;
  logic [1:0] prev_in = 2'b00;
  bit use_discards = 1'b0;

  // Present the next raw bit as each ARM window opens so it is synchronized before SAMPLE.
  always @(negedge clk) begin
    if (en_samp_in == 2'b11 && prev_in != 2'b11 && ent_q.size() > 0)
      ent_y = ent_q.pop_front();
    prev_in = en_samp_in;
  end

  // Output monitor: settle length before each sample pulse, and scoreboard on every transfer.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (rst_n) begin
      if (en_samp_out) begin
        samp_pulses++;
        total++;
        if (arm_run !== SETTLE) begin
          bad++;
          $display("[TB] FAIL settle_len got=%0d want=%0d", arm_run, SETTLE);
        end
        arm_run = 0;
      end else if (en_samp_in == 2'b11) begin
        arm_run++;
        arm_cycles++;
      end else begin
        arm_run = 0;
      end
      if (rnd_valid) valid_cycles++;
      if (rnd_valid && rnd_ready) begin
        xfers++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_byte got=%h want=none", rnd_data);
        end else begin
          exp = exp_q.pop_front();
          if (rnd_data !== exp) begin
            bad++;
            $display("[TB] FAIL rnd_data got=%h want=%h", rnd_data, exp);
          end
        end
      end
    end else begin
      arm_run = 0;
    end
  end

  // Reference model: raw samples to the bytes the consumer should receive.
  function automatic void push_expected(input bit raw[$]);
    logic [7:0] sh = 8'h00;
    int n = 0;
    bit ok;
    bit acc;
`ifdef TRNG_VN_DEBIAS_EN
    bit have_a = 1'b0;
    bit a = 1'b0;
`endif
    foreach (raw[i]) begin
`ifdef TRNG_VN_DEBIAS_EN
      ok = 1'b0;
      acc = 1'b0;
      if (!have_a) begin
        have_a = 1'b1;
        a = raw[i];
      end else begin
        have_a = 1'b0;
        if (a != raw[i]) begin
          ok = 1'b1;
          acc = a;
        end
      end
`else
      ok = 1'b1;
      acc = raw[i];
`endif
      if (ok) begin
        sh = {sh[6:0], acc};
        n++;
        if (n == 8) begin
          exp_q.push_back(sh);
          n = 0;
        end
      end
    end
  endfunction

  function automatic void load(input bit raw[$]);
    foreach (raw[i]) ent_q.push_back(raw[i]);
    push_expected(raw);
  endfunction

  function automatic void byte_bits(input logic [7:0] b, inout bit bits[$]);
    for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
  endfunction

  function automatic void make_raw(input bit bits[$], output bit raw[$]);
    raw.delete();
    foreach (bits[i]) begin
`ifdef TRNG_VN_DEBIAS_EN
      if (use_discards && $urandom_range(0, 2) == 0) begin
        bit x;
        x = 1'($urandom_range(0, 1));
        raw.push_back(x);
        raw.push_back(x);
      end
      raw.push_back(bits[i]);
      raw.push_back(!bits[i]);
`else
      raw.push_back(bits[i]);
`endif
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b0;
    run = 1'b0;
    rnd_ready = 1'b0;
    ent_q.delete();
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_drained(input int budget, output bit done);
    int c = 0;
    while ((exp_q.size() != 0 || ent_q.size() != 0) && c < budget) begin
      step();
      c++;
    end
    done = (exp_q.size() == 0 && ent_q.size() == 0);
  endtask

  task automatic test_reset();
    int a0;
    rst_n = 1'b0;
    #1;
    total += 5;
    if (en_samp_in !== 2'b00) begin bad++; $display("[TB] FAIL rst_en_samp_in got=%b want=00", en_samp_in); end
    if (en_samp_out !== 1'b0) begin bad++; $display("[TB] FAIL rst_en_samp_out got=%b want=0", en_samp_out); end
    if (rnd_data !== 8'h00)   begin bad++; $display("[TB] FAIL rst_rnd_data got=%h want=00", rnd_data); end
    if (rnd_valid !== 1'b0)   begin bad++; $display("[TB] FAIL rst_rnd_valid got=%b want=0", rnd_valid); end
    if (hlth_fail !== 1'b0)   begin bad++; $display("[TB] FAIL rst_hlth_fail got=%b want=0", hlth_fail); end
    do_reset();
    a0 = arm_cycles;
    ena = 1'b1; run = 1'b0;
    repeat (10) step();
    ena = 1'b0; run = 1'b1;
    repeat (10) step();
    total++;
    if (arm_cycles - a0 !== 0) begin
      bad++;
      $display("[TB] FAIL idle_no_arm got=%0d want=0", arm_cycles - a0);
    end
    run = 1'b0;
  endtask

  task automatic test_byte();
    bit raw[$];
    bit done;
    int p0, x0, v0;
`ifdef TRNG_VN_DEBIAS_EN
    raw = '{1,0, 1,1, 0,1, 0,0, 1,0, 1,0, 0,1, 0,1, 1,0, 0,1};
`else
    raw = '{1,0,1,1,0,0,1,0};
`endif
    do_reset();
    load(raw);
    p0 = samp_pulses; x0 = xfers; v0 = valid_cycles;
    ena = 1'b1; run = 1'b1; rnd_ready = 1'b1;
    wait_drained(1000, done);
    run = 1'b0;
    repeat (3) step();
    total += 6;
    if (!done) begin bad++; $display("[TB] FAIL byte_timeout got=pending want=drained"); end
    if (samp_pulses - p0 !== raw.size()) begin bad++; $display("[TB] FAIL byte_pulses got=%0d want=%0d", samp_pulses - p0, raw.size()); end
    if (xfers - x0 !== 1) begin bad++; $display("[TB] FAIL byte_xfers got=%0d want=1", xfers - x0); end
    if (valid_cycles - v0 !== 1) begin bad++; $display("[TB] FAIL byte_valid_len got=%0d want=1", valid_cycles - v0); end
    if (rnd_data !== 8'hB2) begin bad++; $display("[TB] FAIL byte_hold_data got=%h want=b2", rnd_data); end
    if (en_samp_in !== 2'b00) begin bad++; $display("[TB] FAIL byte_idle got=%b want=00", en_samp_in); end
  endtask

  task automatic test_back_to_back();
    bit bits[$];
    bit raw[$];
    int c = 0;
    int x0;
    do_reset();
    for (int k = 0; k < 3; k++) byte_bits(8'($urandom_range(0, 255)), bits);
    use_discards = 1'b1;
    make_raw(bits, raw);
    use_discards = 1'b0;
    load(raw);
    x0 = xfers;
    ena = 1'b1; run = 1'b1;
    while ((exp_q.size() != 0 || ent_q.size() != 0) && c < 3000) begin
      rnd_ready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    run = 1'b0;
    rnd_ready = 1'b1;
    repeat (3) step();
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL b2b_timeout got=%0d want=0", exp_q.size()); end
    if (xfers - x0 !== 3) begin bad++; $display("[TB] FAIL b2b_xfers got=%0d want=3", xfers - x0); end
  endtask

  task automatic test_hold_stall();
    bit bits[$];
    bit raw[$];
    int c = 0;
    int x0, a0;
    logic [7:0] want;
    do_reset();
    byte_bits(8'h3C, bits);
    make_raw(bits, raw);
    load(raw);
    want = exp_q[0];
    ena = 1'b1; run = 1'b1; rnd_ready = 1'b0;
    while (rnd_valid !== 1'b1 && c < 1000) begin
      step();
      c++;
    end
    total++;
    if (rnd_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_timeout got=%b want=1", rnd_valid); end
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (rnd_valid !== 1'b1 || rnd_data !== want) begin
        bad++;
        $display("[TB] FAIL stall_hold cyc=%0d got=%b/%h want=1/%h", i, rnd_valid, rnd_data, want);
      end
    end
    x0 = xfers; a0 = arm_cycles;
    rnd_ready = 1'b1;
    step();
    rnd_ready = 1'b0;
    step();
    total += 2;
    if (xfers - x0 !== 1) begin bad++; $display("[TB] FAIL stall_xfers got=%0d want=1", xfers - x0); end
    if (rnd_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_valid_drop got=%b want=0", rnd_valid); end
    repeat (5) step();
    total++;
    if (arm_cycles - a0 !== 0) begin bad++; $display("[TB] FAIL stall_idle got=%0d want=0", arm_cycles - a0); end
  endtask

  task automatic test_health();
    bit raw[$];
    int c = 0;
    int p0, v0, a0;
    do_reset();
    for (int i = 0; i < 32; i++) raw.push_back(1'b1);
    load(raw);
    p0 = samp_pulses;
    ena = 1'b1; run = 1'b1; rnd_ready = 1'b1;
    while (samp_pulses - p0 < 31 && c < 1000) begin
      step();
      c++;
    end
    total++;
    if (hlth_fail !== 1'b0 || samp_pulses - p0 != 31) begin
      bad++;
      $display("[TB] FAIL health_early got=%b/%0d want=0/31", hlth_fail, samp_pulses - p0);
    end
    c = 0;
    while (hlth_fail !== 1'b1 && c < 100) begin
      step();
      c++;
    end
    total++;
    if (hlth_fail !== 1'b1) begin bad++; $display("[TB] FAIL health_set got=%b want=1", hlth_fail); end
    v0 = valid_cycles; a0 = arm_cycles;
    repeat (50) step();
    total += 4;
    if (valid_cycles - v0 !== 0) begin bad++; $display("[TB] FAIL health_no_valid got=%0d want=0", valid_cycles - v0); end
    if (arm_cycles - a0 !== 0) begin bad++; $display("[TB] FAIL health_idle got=%0d want=0", arm_cycles - a0); end
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL health_bytes got=%0d want=0", exp_q.size()); end
    if (samp_pulses - p0 !== 32) begin bad++; $display("[TB] FAIL health_pulses got=%0d want=32", samp_pulses - p0); end
    rst_n = 1'b0;
    #1;
    total++;
    if (hlth_fail !== 1'b0) begin bad++; $display("[TB] FAIL health_clear got=%b want=0", hlth_fail); end
    step();
    rst_n = 1'b1;
    repeat (2) step();
    total++;
    if (en_samp_in !== 2'b11) begin bad++; $display("[TB] FAIL health_resume got=%b want=11", en_samp_in); end
    run = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit bits1[$];
    bit bits2[$];
    bit bits3[$];
    bit raw1[$];
    bit raw2[$];
    bit raw3[$];
    bit done;
    int c = 0;
    int p0;
    do_reset();
    byte_bits(8'hC3, bits1);
    for (int i = 0; i < 5; i++) bits2.push_back(1'($urandom_range(0, 1)));
    make_raw(bits1, raw1);
    make_raw(bits2, raw2);
    load(raw1);
    load(raw2);
    p0 = samp_pulses;
    ena = 1'b1; run = 1'b1; rnd_ready = 1'b1;
    while (samp_pulses - p0 < raw1.size() + raw2.size() && c < 1000) begin
      step();
      c++;
    end
    c = 0;
    while (en_samp_in !== 2'b11 && c < 20) begin
      step();
      c++;
    end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total += 5;
    if (en_samp_in !== 2'b00) begin bad++; $display("[TB] FAIL mid_en_samp_in got=%b want=00", en_samp_in); end
    if (en_samp_out !== 1'b0) begin bad++; $display("[TB] FAIL mid_en_samp_out got=%b want=0", en_samp_out); end
    if (rnd_data !== 8'h00)   begin bad++; $display("[TB] FAIL mid_rnd_data got=%h want=00", rnd_data); end
    if (rnd_valid !== 1'b0)   begin bad++; $display("[TB] FAIL mid_rnd_valid got=%b want=0", rnd_valid); end
    if (hlth_fail !== 1'b0)   begin bad++; $display("[TB] FAIL mid_hlth_fail got=%b want=0", hlth_fail); end
    ent_q.delete();
    exp_q.delete();
    byte_bits(8'h5A, bits3);
    make_raw(bits3, raw3);
    load(raw3);
    step();
    rst_n = 1'b1;
    wait_drained(1000, done);
    run = 1'b0;
    repeat (3) step();
    total++;
    if (!done) begin bad++; $display("[TB] FAIL mid_timeout got=pending want=drained"); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_byte();
    test_back_to_back();
    test_hold_stall();
    test_health();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trng_sample_ctrl.md
TRNG_SAMPLE_CTRL -- requirements
Module: trng_sample_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 4: cycles en_samp_in is held high before each sample capture (legal range 1..255).
REQ-002 Parameter REP_LIMIT, default 32: consecutive identical raw samples that trip the health check.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  design enable; low acts as run low.
REQ-006 run  input  1  level request for continuous byte generation.
REQ-007 ent_y  input  1  raw asynchronous entropy-cell output.
REQ-008 en_samp_in  output  2  entropy-cell input-sampling enables, both bits driven identically.
REQ-009 en_samp_out  output  1  entropy-cell output-latch enable.
REQ-010 rnd_data  output  8  assembled random byte.
REQ-011 rnd_valid  output  1  rnd_data is valid.
REQ-012 rnd_ready  input  1  consumer accepts the byte.
REQ-013 hlth_fail  output  1  sticky repetition-count failure flag.

Function
REQ-014 ent_y SHALL pass a 2-flop synchronizer; "sample" means the synchronizer output registered in SAMPLE state.
REQ-015 FSM states SHALL be IDLE, ARM, SAMPLE, HOLD.
REQ-016 IDLE: all outputs 0 except rnd_data holds; go to ARM when ena & run & !hlth_fail, loading settle counter with SETTLE_CYC-1.
REQ-017 ARM: en_samp_in=2'b11; counter decrements each cycle; at 0 go to SAMPLE.
REQ-018 SAMPLE: en_samp_in=2'b00, en_samp_out=1 for exactly one cycle; sample captured at end of that cycle.
REQ-019 After SAMPLE: if 8 accepted bits collected go to HOLD, else return to ARM with counter reloaded.
REQ-020 Accepted bits SHALL shift into rnd_data position MSB-first (first accepted bit ends in bit 7).
REQ-021 HOLD: rnd_valid=1, rnd_data stable; transfer occurs on the cycle rnd_valid & rnd_ready are both high.
REQ-022 After transfer: rnd_valid=0 next cycle; go to ARM if ena & run & !hlth_fail, else IDLE; bit count cleared.
REQ-023 run or ena low in ARM or SAMPLE: go to IDLE next cycle, partial bits discarded, bit count cleared.
REQ-024 run or ena low in HOLD: byte remains valid until transferred (no retraction).
REQ-025 Repetition counter SHALL count consecutive identical raw samples (before debiasing), saturating at REP_LIMIT.
REQ-026 When count reaches REP_LIMIT, hlth_fail SHALL set on the next cycle and stay set until reset; FSM goes to IDLE unless in HOLD, the partial byte is discarded, and no further rnd_valid is raised after any pending HOLD transfer.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE; rnd_data=8'h00, rnd_valid=0, en_samp_in=2'b00, en_samp_out=0, hlth_fail=0; all counters and synchronizer flops 0.
REQ-028 Reset release SHALL take effect on the first clk rising edge with rst_n high.

Configuration
REQ-029 Macro TRNG_VN_DEBIAS_EN defined: samples processed in pairs (a then b); a!=b accepts bit a; a==b discards both; odd pending sample is discarded on REQ-023 abort.
REQ-030 Macro not defined: every sample is accepted directly; no pairing logic is compiled.

Structure
REQ-031 Package trng_pkg SHALL hold the FSM state enum, default SETTLE_CYC and REP_LIMIT constants, and BYTE_W=8.
REQ-032 Pair logic SHALL be a sub-module trng_vn_debias (inputs sample strobe and bit, outputs accept strobe and bit), instantiated only under TRNG_VN_DEBIAS_EN.

Verification
REQ-033 No debias, SETTLE_CYC=4, ent_y pattern 1,0,1,1,0,0,1,0 per sample, rnd_ready=1 -> rnd_data=8'hB2, rnd_valid one cycle, 8 en_samp_out pulses each preceded by 4 en_samp_in-high cycles.
REQ-034 Debias, sample pairs 10,11,01,00,10,10,01,01,10,01 -> accepted 1,0,1,1,0,0,1,0, rnd_data=8'hB2.
REQ-035 HOLD with rnd_ready=0 for 10 cycles, run dropped meanwhile -> rnd_data stable, rnd_valid held high; on ready, one transfer, then IDLE.
REQ-036 ent_y held 1 for 32 samples -> hlth_fail=1, FSM in IDLE, no rnd_valid thereafter even with run=1, until rst_n pulse clears flag.
REQ-037 rst_n asserted mid-ARM after 5 accepted bits -> outputs immediately at reset values; after release and run, the next byte contains only newly captured bits.
